mem_mult_ctrl: RTL

MEM_MULT_CTRL -- requirements
Module: mem_mult_ctrl

---
 rtl/mem_mult_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_mult_ctrl.sv
// 16x8 register file shared by a host port and a 4x4 shift-add multiply sequencer.
// Each job reads two operand nibbles, multiplies them and writes the byte product back.
module mem_mult_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        MUL  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] src_a_l;
    logic [ADDR_W-1:0] src_b_l;
    logic [ADDR_W-1:0] dst_l;
    logic [3:0]        m;
    logic [3:0]        q;
    logic [3:0]        a;
    logic              c;
    logic [1:0]        cnt;
    logic [4:0]        sum;
    logic [8:0]        shifted;

    // One shift-add step: conditional add into {C,A}, then shift {C,A,Q} right.
    always_comb begin
        sum     = {c, a};
        if (q[0]) begin
            sum = {1'b0, a} + {1'b0, m};
        end
        shifted = {sum, q} >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            host_rdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product    <= '0;
            src_a_l    <= '0;
            src_b_l    <= '0;
            dst_l      <= '0;
            m          <= '0;
            q          <= '0;
            a          <= '0;
            c          <= 1'b0;
            cnt        <= '0;
        end else begin
            host_rdata <= mem[host_addr];
            // Host writes land only while the sequencer is not using the memory.
            if (host_we && (state == IDLE || state == DONE)) begin
                mem[host_addr] <= host_wdata;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        src_a_l <= src_a;
                        src_b_l <= src_b;
                        dst_l   <= dst;
                        busy    <= 1'b1;
                        state   <= RD_A;
                    end
                end
                RD_A: begin
                    m     <= mem[src_a_l][3:0];
                    state <= RD_B;
                end
                RD_B: begin
                    q     <= mem[src_b_l][3:0];
                    a     <= '0;
                    c     <= 1'b0;
                    cnt   <= 2'd3;
                    state <= MUL;
                end
                MUL: begin
                    c <= shifted[8];
                    a <= shifted[7:4];
                    q <= shifted[3:0];
                    if (cnt == 2'd0) begin
                        state <= WR;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                WR: begin
                    mem[dst_l] <= {a, q};
                    product    <= {a, q};
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
